// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: FSM state encodings, data-register load sources
// and the RV32I NOP used as the default bubble payload.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SRC_D   = 2'd0,
      SRC_ALT = 2'd1,
      SRC_NOP = 2'd2
   } ld_src_e;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   function automatic logic [1:0] occ_of(input state_e s);
      case (s)
         ST_FULL: return 2'd1;
         ST_SKID: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Ready/valid bus of one pipeline stage: upstream payload in, downstream payload out, occupancy.
// master drives payloads in and accepts them out; slave is the stage itself.
interface pipe_stage_skid_reg_if #(
   parameter int unsigned NrOfBits = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [NrOfBits-1:0] D;
   logic                out_valid;
   logic                out_ready;
   logic [NrOfBits-1:0] Q;
   logic [1:0]          Occupancy;

   modport master (
      output in_valid, D, out_ready,
      input  in_ready, out_valid, Q, Occupancy
   );

   modport slave (
      input  in_valid, D, out_ready,
      output in_ready, out_valid, Q, Occupancy
   );
endinterface

// File: rtl/pipe_data_reg.sv
// Width-parametrised data register: synchronous reset value, load enable, 3-way load-value mux.
// One cycle load latency; no handshake of its own, the owner decides when to load.
module pipe_data_reg
   import pipe_pkg::*;
#(
   parameter int unsigned         Width    = 32,
   parameter logic [Width-1:0]    RstValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ld_i,
   input  ld_src_e          src_i,
   input  logic [Width-1:0] d_i,
   input  logic [Width-1:0] alt_i,
   input  logic [Width-1:0] nop_i,
   output logic [Width-1:0] q_o
);
   logic [Width-1:0] data_q;
   logic [Width-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (ld_i) begin
         case (src_i)
            SRC_D:   data_d = d_i;
            SRC_ALT: data_d = alt_i;
            default: data_d = nop_i;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) data_q <= RstValue;
      else       data_q <= data_d;
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with one-entry skid buffer; D->Q is 1 cycle, a skidded entry follows the next pop.
// in_ready/out_valid are registered, so back-pressure never forms a combinational path across stages.
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned          NrOfBits   = 32,
   parameter logic [NrOfBits-1:0]  ResetValue = '0,
   parameter logic [NrOfBits-1:0]  NopValue   = NrOfBits'(RV_NOP)
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Tick,
   input  logic                 Flush,
   pipe_stage_skid_reg_if.slave bus
);
   state_e              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [1:0]          occ_q, occ_d;
   logic                push, pop;
   logic                main_ld, skid_ld;
   ld_src_e             main_src, skid_src;
   logic [NrOfBits-1:0] main_q, skid_q;

   assign push = bus.in_valid & in_ready_q & Tick;
   assign pop  = out_valid_q & bus.out_ready & Tick;

   always_comb begin
      state_d  = state_q;
      main_ld  = 1'b0;
      main_src = SRC_D;
      skid_ld  = 1'b0;
      skid_src = SRC_D;
      if (Flush) begin
         state_d  = ST_EMPTY;
         main_ld  = 1'b1;
         main_src = SRC_NOP;
         skid_ld  = 1'b1;
         skid_src = SRC_NOP;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_d = ST_FULL;
                  main_ld = 1'b1;
               end
            end
            ST_FULL: begin
               if (push && pop) begin
                  main_ld = 1'b1;
               end else if (push) begin
                  state_d = ST_SKID;
                  skid_ld = 1'b1;
               end else if (pop) begin
                  state_d  = ST_EMPTY;
                  main_ld  = 1'b1;
                  main_src = SRC_NOP;
               end
            end
            ST_SKID: begin
               if (pop) begin
                  state_d  = ST_FULL;
                  main_ld  = 1'b1;
                  main_src = SRC_ALT;
                  skid_ld  = 1'b1;
                  skid_src = SRC_NOP;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      // Handshake outputs are precomputed from the next state so they can be registered.
      in_ready_d  = (state_d != ST_SKID);
      out_valid_d = (state_d != ST_EMPTY);
      occ_d       = occ_of(state_d);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         occ_q       <= occ_d;
      end
   end

   pipe_data_reg #(
      .Width    (NrOfBits),
      .RstValue (ResetValue)
   ) u_main (
      .clk_i (Clock),
      .rst_i (Reset),
      .ld_i  (main_ld),
      .src_i (main_src),
      .d_i   (bus.D),
      .alt_i (skid_q),
      .nop_i (NopValue),
      .q_o   (main_q)
   );

   pipe_data_reg #(
      .Width    (NrOfBits),
      .RstValue (NopValue)
   ) u_skid (
      .clk_i (Clock),
      .rst_i (Reset),
      .ld_i  (skid_ld),
      .src_i (skid_src),
      .d_i   (bus.D),
      .alt_i ('0),
      .nop_i (NopValue),
      .q_o   (skid_q)
   );

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.Occupancy = occ_q;
   assign bus.Q         = main_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Three stage widths (1, 32, 64) driven by the same control stream, checked against a queue model.
module tb_pipe_stage_skid_reg;

   logic        Clock;
   logic        Reset, Tick, Flush;
   logic        iv, ordy;
   logic [63:0] dv;

   int n_checks = 0;
   int n_errs   = 0;

   localparam logic [31:0] RV32 = 32'hDEAD_BEEF;
   localparam logic [0:0]  RV1  = 1'b1;
   localparam logic [63:0] RV64 = 64'h0123_4567_89AB_CDEF;

   pipe_stage_skid_reg_if #(.NrOfBits(32)) bus32 ();
   pipe_stage_skid_reg_if #(.NrOfBits(1))  bus1  ();
   pipe_stage_skid_reg_if #(.NrOfBits(64)) bus64 ();

   assign bus32.in_valid = iv;  assign bus32.out_ready = ordy;  assign bus32.D = dv[31:0];
   assign bus1.in_valid  = iv;  assign bus1.out_ready  = ordy;  assign bus1.D  = dv[0];
   assign bus64.in_valid = iv;  assign bus64.out_ready = ordy;  assign bus64.D = dv;

   pipe_stage_skid_reg #(.NrOfBits(32), .ResetValue(RV32)) u_w32 (
      .Clock(Clock), .Reset(Reset), .Tick(Tick), .Flush(Flush), .bus(bus32));
   pipe_stage_skid_reg #(.NrOfBits(1), .ResetValue(RV1)) u_w1 (
      .Clock(Clock), .Reset(Reset), .Tick(Tick), .Flush(Flush), .bus(bus1));
   pipe_stage_skid_reg #(.NrOfBits(64), .ResetValue(RV64)) u_w64 (
      .Clock(Clock), .Reset(Reset), .Tick(Tick), .Flush(Flush), .bus(bus64));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Reference: held payloads in arrival order; when empty, Q shows reset value or bubble.
   logic [63:0] mq[$];
   bit          m_rst = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mask(input int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
   endfunction

   function automatic logic [63:0] exp_q(input int w, input logic [63:0] rv);
      if (mq.size() > 0) return mq[0] & mask(w);
      return (m_rst ? rv : 64'h13) & mask(w);
   endfunction

   task automatic check_all();
      logic [63:0] e_vld, e_rdy, e_occ;
      e_vld = 64'(mq.size() > 0);
      e_rdy = 64'(mq.size() < 2);
      e_occ = 64'(mq.size());
      chk("q32",   64'(bus32.Q),         exp_q(32, 64'(RV32)));
      chk("vld32", 64'(bus32.out_valid), e_vld);
      chk("rdy32", 64'(bus32.in_ready),  e_rdy);
      chk("occ32", 64'(bus32.Occupancy), e_occ);
      chk("q1",    64'(bus1.Q),          exp_q(1, 64'(RV1)));
      chk("vld1",  64'(bus1.out_valid),  e_vld);
      chk("rdy1",  64'(bus1.in_ready),   e_rdy);
      chk("occ1",  64'(bus1.Occupancy),  e_occ);
      chk("q64",   bus64.Q,              exp_q(64, RV64));
      chk("vld64", 64'(bus64.out_valid), e_vld);
      chk("rdy64", 64'(bus64.in_ready),  e_rdy);
      chk("occ64", 64'(bus64.Occupancy), e_occ);
   endtask

   task automatic step(input bit rst, input bit tk, input bit fl, input bit v,
                       input bit o, input logic [63:0] d);
      int  n;
      bit  push, pop;
      Reset = rst; Tick = tk; Flush = fl; iv = v; ordy = o; dv = d;
      @(posedge Clock);
      n = mq.size();
      if (rst) begin
         mq.delete();
         m_rst = 1'b1;
      end else if (fl) begin
         mq.delete();
         m_rst = 1'b0;
      end else begin
         push = v && (n < 2) && tk;
         pop  = (n > 0) && o && tk;
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(d);
         if (pop && mq.size() == 0) m_rst = 1'b0;
      end
      @(negedge Clock);
      check_all();
   endtask

   initial begin
      Reset = 1'b1; Tick = 1'b0; Flush = 1'b0; iv = 1'b0; ordy = 1'b0; dv = '0;

      step(1, 1, 0, 0, 0, 64'd0);
      step(1, 1, 0, 0, 0, 64'd0);
      chk("rst_q",   64'(bus32.Q), 64'hDEAD_BEEF);
      chk("rst_vld", 64'(bus32.out_valid), 64'd0);
      chk("rst_rdy", 64'(bus32.in_ready), 64'd1);
      chk("rst_occ", 64'(bus32.Occupancy), 64'd0);

      for (int k = 1; k <= 3; k++) begin
         step(0, 1, 0, 1, 1, 64'(k));
         chk("stream_q",   64'(bus32.Q), 64'(k));
         chk("stream_rdy", 64'(bus32.in_ready), 64'd1);
      end
      step(0, 1, 0, 0, 1, 64'd0);
      chk("drain_q", 64'(bus32.Q), 64'h13);

      step(0, 1, 0, 1, 0, 64'hA);
      step(0, 1, 0, 1, 0, 64'hB);
      chk("bp_occ", 64'(bus32.Occupancy), 64'd2);
      chk("bp_rdy", 64'(bus32.in_ready), 64'd0);
      chk("bp_qa",  64'(bus32.Q), 64'hA);
      step(0, 1, 0, 0, 1, 64'd0);
      chk("bp_qb",  64'(bus32.Q), 64'hB);
      step(0, 1, 0, 0, 1, 64'd0);
      chk("bp_nop", 64'(bus32.Q), 64'h13);
      chk("bp_vld", 64'(bus32.out_valid), 64'd0);

      step(0, 1, 0, 1, 0, 64'h21);
      step(0, 1, 0, 1, 0, 64'h22);
      step(0, 1, 1, 1, 0, 64'hC);
      chk("fl_occ", 64'(bus32.Occupancy), 64'd0);
      chk("fl_q",   64'(bus32.Q), 64'h13);
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 0, 0, 1, 64'd0);
         chk("fl_noc", 64'(bus32.Q), 64'h13);
      end

      step(0, 1, 0, 1, 0, 64'h31);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 1, 1, 64'h32);
         chk("tick_q",   64'(bus32.Q), 64'h31);
         chk("tick_occ", 64'(bus32.Occupancy), 64'd1);
      end
      step(0, 1, 0, 1, 1, 64'h32);
      chk("tick_go", 64'(bus32.Q), 64'h32);

      for (int c = 0; c < 600; c++) begin
         step($urandom_range(63) == 0,
              $urandom_range(3) != 0,
              $urandom_range(15) == 0,
              $urandom_range(1) == 1,
              $urandom_range(2) != 0,
              {$urandom, $urandom});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid_reg.md
# pipe_stage_skid_reg

Parametrised pipeline stage register with a ready/valid handshake and a one-entry skid buffer. It is the next generation of the per-stage register used between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds back-pressure, flush-to-bubble and a configurable reset/bubble encoding. Every `in_ready` and `out_valid` output is driven from a register, so stall paths are broken between stages.

## Interface
- `NrOfBits`, 32: payload width, 1..256.
- `ResetValue`, 0: value of the main register after `Reset`.
- `NopValue`, 32'h0000_0013: bubble payload loaded on `Flush` and on drain to empty. This is the RV32I NOP encoding.

- `Clock`  in  1  sole clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high; highest priority.
- `Tick`  in  1  global advance enable; handshakes complete only when high.
- `Flush`  in  1  synchronous discard of all held entries.
- `in_valid`  in  1  upstream has a payload on `D`.
- `in_ready`  out  1  stage can accept; registered.
- `D`  in  NrOfBits  upstream payload.
- `out_valid`  out  1  `Q` holds a valid payload; registered.
- `out_ready`  in  1  downstream accepts.
- `Q`  out  NrOfBits  main register contents.
- `Occupancy`  out  2  number of valid entries, 0..2.

## Operation
- Handshake terms:
  - push = `in_valid & in_ready & Tick`.
  - pop = `out_valid & out_ready & Tick`.
- State machine:
  - EMPTY: `Occupancy`=0, `out_valid`=0, `in_ready`=1.
  - FULL: `Occupancy`=1, `out_valid`=1, `in_ready`=1.
  - SKID: `Occupancy`=2, `out_valid`=1, `in_ready`=0.
- Transitions from EMPTY:
  - push → FULL, main←`D`.
  - no push → stay EMPTY.
- Transitions from FULL:
  - push&pop → FULL, main←`D`.
  - push only → SKID, skid←`D`.
  - pop only → EMPTY, main←`NopValue`.
  - neither → hold.
- Transitions from SKID:
  - push is impossible because `in_ready`=0.
  - pop → FULL, main←skid, skid←`NopValue`.
  - no pop → hold.
- Priority is `Reset` > `Flush` > push/pop.
- `Reset` forces:
  - state EMPTY;
  - main←`ResetValue`;
  - skid←`NopValue`;
  - `in_ready`=1, `out_valid`=0, `Occupancy`=0.
- `Flush` acts regardless of `Tick`. It forces:
  - state EMPTY;
  - main←`NopValue`;
  - skid←`NopValue`.
  - A simultaneous push is discarded.
- `Tick`=0: state and data hold, except under `Reset` or `Flush`.
  - `in_ready` and `out_valid` keep reflecting the current state.
  - No transfer is counted.
- `Q` always equals main. When `out_valid`=0, `Q` equals `ResetValue` or `NopValue`, never stale data.
- Order is FIFO: the skid entry is always older-than-next-`D` and younger than main.
- Payload is never altered, truncated or widened.

## Timing
- D→Q latency is 1 cycle when pushing into EMPTY, or into FULL with a simultaneous pop.
- A payload pushed while FULL without a pop reaches `Q` 1 cycle after the pop of the current main.
- `in_ready` deasserts the cycle after the FULL→SKID push. It reasserts the cycle after the pop that leaves SKID.
- There is no combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- Sustained throughput is 1 payload per `Tick` cycle when `out_ready`=1.
- `Reset` or `Flush` asserted mid-transfer takes effect on that same edge. Outputs show the cleared values from the next cycle.

## Structure
- Shared package `pipe_pkg` holds:
  - state encodings: `ST_EMPTY`=2'd0, `ST_FULL`=2'd1, `ST_SKID`=2'd2;
  - `RV_NOP`=32'h0000_0013, used as the `NopValue` default.
- One sub-module, `pipe_data_reg`: a width-parametrised register with synchronous reset value, load enable and load-value mux. It is instantiated twice, for main and skid.
- The control FSM stays in the top module.

## Test plan
- Reset: hold `Reset` for 2 cycles with `ResetValue`=32'hDEAD_BEEF → `Q`=32'hDEAD_BEEF, `out_valid`=0, `in_ready`=1, `Occupancy`=0.
- Streaming: `out_ready`=1, `Tick`=1, push 1,2,3 on consecutive cycles → `Q`=1,2,3 one cycle after each push, `in_ready` stays 1.
- Back-pressure: `out_ready`=0, push 0xA then 0xB:
  - expect `Occupancy`=2 and `in_ready`=0;
  - then `out_ready`=1 → `Q` shows 0xA, then 0xB, then `NopValue` with `out_valid`=0.
- Flush in SKID: with 2 entries held, assert `Flush` together with `in_valid` carrying 0xC → next cycle `Occupancy`=0, `Q`=32'h13, 0xC never appears.
- `Tick` gating: FULL state, `Tick`=0, `in_valid`=1, `out_ready`=1 for 3 cycles → no state change, `Q` unchanged. Raising `Tick` completes push and pop in 1 cycle.
- Width/default sweep: repeat the streaming test with `NrOfBits`=1 and `NrOfBits`=64 → order and values preserved, no X on `Q` after reset.
